// File: rtl/jc_decoder.sv
// Johnson-code receive checker: decodes a twisted-ring count to a binary index and
// one-hot vector, flags illegal codes and out-of-sequence steps, and tracks lock.
module jc_decoder #(
   parameter int N        = 4,
   parameter int LOCK_CNT = 3,
   parameter int IW       = $clog2(2*N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [N-1:0]      code,
   input  logic              err_clr,
   output logic [IW-1:0]     idx,
   output logic [2*N-1:0]    onehot,
   output logic              out_vld,
   output logic              locked,
   output logic              code_err,
   output logic              seq_err,
   output logic [7:0]        err_cnt
);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [3:0]    LOCK_C  = 4'(LOCK_CNT);
   localparam logic [IW-1:0] LAST_IX = IW'(2*N-1);

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [2*N-1:0]    onehot_q, onehot_d;
   logic              out_vld_q, out_vld_d;
   logic              ref_vld_q, ref_vld_d;
   logic [3:0]        match_cnt_q, match_cnt_d;
   logic              code_err_q, code_err_d;
   logic              seq_err_q, seq_err_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic              dec_legal;
   logic [IW-1:0]     dec_idx;
   logic [IW-1:0]     succ_idx;
   logic              any_err;

   // Legal pattern for index i: i low ones while filling, then zeros shift in from bit0.
   function automatic logic [N-1:0] jpat(input int i);
      logic [N-1:0] p;
      p = '0;
      for (int b = 0; b < N; b++) begin
         if (i <= N) p[b] = (b < i);
         else        p[b] = (b >= i - N);
      end
      return p;
   endfunction

   always_comb begin
      dec_legal = 1'b0;
      dec_idx   = '0;
      for (int i = 0; i < 2*N; i++) begin
         if (code == jpat(i)) begin
            dec_legal = 1'b1;
            dec_idx   = IW'(i);
         end
      end
   end

   assign succ_idx = (idx_q == LAST_IX) ? '0 : idx_q + IW'(1);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      onehot_d    = onehot_q;
      out_vld_d   = out_vld_q;
      ref_vld_d   = ref_vld_q;
      match_cnt_d = match_cnt_q;
      code_err_d  = 1'b0;
      seq_err_d   = 1'b0;

      if (valid) begin
         if (!dec_legal) begin
            code_err_d  = 1'b1;
            state_d     = UNLOCKED;
            match_cnt_d = '0;
            ref_vld_d   = 1'b0;
         end else if (!ref_vld_q) begin
            idx_d       = dec_idx;
            out_vld_d   = 1'b1;
            ref_vld_d   = 1'b1;
            match_cnt_d = '0;
         end else if (dec_idx == idx_q) begin
            // A repeated code is a hold: nothing moves.
            idx_d = idx_q;
         end else if (dec_idx == succ_idx) begin
            idx_d = dec_idx;
            if (state_q == UNLOCKED) begin
               match_cnt_d = match_cnt_q + 4'd1;
               if (match_cnt_q + 4'd1 == LOCK_C) state_d = LOCKED;
            end
         end else begin
            idx_d       = dec_idx;
            match_cnt_d = '0;
            if (state_q == LOCKED) begin
               seq_err_d = 1'b1;
               state_d   = UNLOCKED;
            end
         end
         if (dec_legal) begin
            onehot_d          = '0;
            onehot_d[idx_d]   = 1'b1;
         end
      end
   end

   assign any_err = code_err_d | seq_err_d;

   // Clear wins over the old count but not over an error on the same edge.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr)                          err_cnt_d = any_err ? 8'd1 : 8'd0;
      else if (any_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= UNLOCKED;
         idx_q       <= '0;
         onehot_q    <= '0;
         out_vld_q   <= 1'b0;
         ref_vld_q   <= 1'b0;
         match_cnt_q <= '0;
         code_err_q  <= 1'b0;
         seq_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         onehot_q    <= onehot_d;
         out_vld_q   <= out_vld_d;
         ref_vld_q   <= ref_vld_d;
         match_cnt_q <= match_cnt_d;
         code_err_q  <= code_err_d;
         seq_err_q   <= seq_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign idx      = idx_q;
   assign onehot   = onehot_q;
   assign out_vld  = out_vld_q;
   assign locked   = (state_q == LOCKED);
   assign code_err = code_err_q;
   assign seq_err  = seq_err_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_jc_decoder.sv
// Directed bench for jc_decoder (N=4, LOCK_CNT=3): a table-driven reference model feeds an
// expected-output queue that is popped after every sampled edge, plus targeted spot checks.
module tb_jc_decoder;

   localparam int N  = 4;
   localparam int IW = 3;
   localparam int EW = IW + 2*N + 4 + 8;

   logic           clk;
   logic           rst_n;
   logic           valid;
   logic [N-1:0]   code;
   logic           err_clr;
   logic [IW-1:0]  idx;
   logic [2*N-1:0] onehot;
   logic           out_vld;
   logic           locked;
   logic           code_err;
   logic           seq_err;
   logic [7:0]     err_cnt;

   int total = 0;
   int bad   = 0;

   logic [EW-1:0] exp_q[$];

   // reference model state
   bit       m_ref;
   int       m_idx;
   bit       m_vld;
   bit       m_lock;
   int       m_cnt;
   int       m_err;
   bit       m_ce;
   bit       m_se;

   jc_decoder #(.N(N), .LOCK_CNT(3)) dut (
      .clk      (clk),
      .rst      (rst_n),
      .valid    (valid),
      .code     (code),
      .err_clr  (err_clr),
      .idx      (idx),
      .onehot   (onehot),
      .out_vld  (out_vld),
      .locked   (locked),
      .code_err (code_err),
      .seq_err  (seq_err),
      .err_cnt  (err_cnt)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- model ----------------
   function automatic int jidx(input logic [3:0] c);
      case (c)
         4'b0000: return 0;
         4'b0001: return 1;
         4'b0011: return 2;
         4'b0111: return 3;
         4'b1111: return 4;
         4'b1110: return 5;
         4'b1100: return 6;
         4'b1000: return 7;
         default: return -1;
      endcase
   endfunction

   function automatic logic [EW-1:0] pack(input logic [IW-1:0] i, input logic [2*N-1:0] oh,
                                          input logic v, input logic l, input logic ce,
                                          input logic se, input logic [7:0] e);
      return {i, oh, v, l, ce, se, e};
   endfunction

   task automatic model_reset();
      m_ref = 0; m_idx = 0; m_vld = 0; m_lock = 0; m_cnt = 0; m_err = 0; m_ce = 0; m_se = 0;
   endtask

   task automatic model_step(input logic v, input logic [3:0] c, input logic clr);
      int k;
      logic [2*N-1:0] oh;
      m_ce = 0;
      m_se = 0;
      if (v) begin
         k = jidx(c);
         if (k < 0) begin
            m_ce = 1; m_lock = 0; m_cnt = 0; m_ref = 0;
         end else if (!m_ref) begin
            m_idx = k; m_vld = 1; m_cnt = 0; m_ref = 1;
         end else if (k == m_idx) begin
            m_ref = 1;
         end else if (k == (m_idx + 1) % 8) begin
            m_idx = k;
            if (!m_lock) begin
               m_cnt++;
               if (m_cnt == 3) m_lock = 1;
            end
         end else begin
            m_idx = k; m_cnt = 0;
            if (m_lock) begin
               m_se = 1; m_lock = 0;
            end
         end
      end
      if (clr)                       m_err = (m_ce || m_se) ? 1 : 0;
      else if ((m_ce || m_se) && m_err < 255) m_err++;
      oh = m_vld ? (8'd1 << m_idx) : 8'd0;
      exp_q.push_back(pack(IW'(m_idx), oh, m_vld, m_lock, m_ce, m_se, 8'(m_err)));
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [EW-1:0] dut_vec();
      return pack(idx, onehot, out_vld, locked, code_err, seq_err, err_cnt);
   endfunction

   // ---------------- driver ----------------
   task automatic step(input logic v, input logic [3:0] c, input logic clr, input string tag);
      logic [EW-1:0] e;
      @(negedge clk);
      valid   = v;
      code    = c;
      err_clr = clr;
      model_step(v, c, clr);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         total++; bad++;
         $display("FAIL %s got=empty_queue exp=entry", tag);
      end else begin
         e = exp_q.pop_front();
         check(tag, 32'(dut_vec()), 32'(e));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] c;
      rst_n = 1'b0; valid = 1'b0; code = '0; err_clr = 1'b0;
      model_reset();
      #12;
      check("reset_state", 32'(dut_vec()), 32'(pack('0, '0, 0, 0, 0, 0, 8'd0)));
      @(negedge clk);
      rst_n = 1'b1;

      // acquire lock
      step(1, 4'b0000, 0, "lock0");
      step(1, 4'b0001, 0, "lock1");
      step(1, 4'b0011, 0, "lock2");
      check("not_locked_yet", 32'(locked), 32'd0);
      step(1, 4'b0111, 0, "lock3");
      check("locked_after_4", 32'(locked), 32'd1);
      check("lock_onehot", 32'(onehot), 32'h08);

      // illegal code while locked, then relock
      step(1, 4'b0101, 0, "illegal");
      check("illegal_pulse", 32'({code_err, locked, idx, err_cnt}), 32'({1'b1, 1'b0, 3'd3, 8'd1}));
      step(0, 4'b0101, 0, "illegal_pulse_end");
      check("code_err_one_cycle", 32'(code_err), 32'd0);
      step(1, 4'b0111, 0, "rel0");
      step(1, 4'b1111, 0, "rel1");
      step(1, 4'b1110, 0, "rel2");
      step(1, 4'b1100, 0, "rel3");
      check("relocked_idx6", 32'({locked, idx}), 32'({1'b1, 3'd6}));

      // wrap 6->7->0->1->2 while locked, then skip to 4
      step(1, 4'b1000, 0, "wrap7");
      step(1, 4'b0000, 0, "wrap0");
      step(1, 4'b0001, 0, "wrap1");
      step(1, 4'b0011, 0, "wrap2");
      check("wrap_no_err", 32'({locked, err_cnt}), 32'({1'b1, 8'd1}));
      step(1, 4'b1111, 0, "skip");
      check("skip_seq_err", 32'({seq_err, locked, idx, err_cnt}), 32'({1'b1, 1'b0, 3'd4, 8'd2}));

      // relock and land on idx 2 for the hold test
      step(1, 4'b1110, 0, "r5");
      step(1, 4'b1100, 0, "r6");
      step(1, 4'b1000, 0, "r7");
      step(1, 4'b0000, 0, "r0");
      step(1, 4'b0001, 0, "r1");
      step(1, 4'b0011, 0, "r2");
      for (int i = 0; i < 3; i++) begin
         step(0, 4'b1010, 0, "gap");
         step(1, 4'b0011, 0, "hold");
      end
      step(0, 4'bxxxx, 0, "gap_x");
      check("hold_state", 32'({locked, idx, err_cnt}), 32'({1'b1, 3'd2, 8'd2}));

      // saturate the error counter with random illegal codes
      for (int i = 0; i < 260; i++) begin
         do c = 4'($urandom_range(0, 15)); while (jidx(c) >= 0);
         step(1, c, 0, "sat");
      end
      check("err_sat", 32'(err_cnt), 32'd255);
      step(1, 4'b1010, 1, "clr_with_err");
      check("clr_with_err_is1", 32'(err_cnt), 32'd1);
      step(0, 4'b0000, 1, "clr_alone");
      check("clr_alone_is0", 32'(err_cnt), 32'd0);

      // lock again, then asynchronous reset mid-cycle
      step(1, 4'b0000, 0, "a0");
      step(1, 4'b0001, 0, "a1");
      step(1, 4'b0011, 0, "a2");
      step(1, 4'b0111, 0, "a3");
      check("pre_reset_locked", 32'(locked), 32'd1);
      #2;
      rst_n = 1'b0;
      valid = 1'b0;
      #1;
      check("async_reset", 32'(dut_vec()), 32'(pack('0, '0, 0, 0, 0, 0, 8'd0)));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 4'b1110, 0, "post_reset_first");
      check("post_reset_idx5", 32'({out_vld, idx, locked, code_err, seq_err}),
            32'({1'b1, 3'd5, 1'b0, 1'b0, 1'b0}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jc_decoder.md
Name: jc_decoder

Overview:
- Receive-side checker and decoder for an N-bit Johnson (twisted-ring) count stream, as produced by the team's Johnson counters.
- Samples the code when `valid` is high and converts it to a binary index and a one-hot vector.
- Detects illegal patterns and out-of-sequence steps, and tracks lock to the counter with a small FSM.
- Sits between any Johnson-coded state source and downstream logic that needs a binary phase.

Parameters:
- N, 4: Johnson code width; the sequence has 2N legal states.
- LOCK_CNT, 3: consecutive correct successor samples required to assert `locked` (1..15).
- IW, $clog2(2*N): index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (all state cleared while low).
- valid  input  1  sample strobe; `code` is evaluated only when high.
- code  input  N  Johnson-coded state, bit0 = first stage.
- err_clr  input  1  synchronous clear of `err_cnt`.
- idx  output  IW  decoded binary index of last legal code.
- onehot  output  2N  one-hot of `idx`; all-zero until `out_vld`.
- out_vld  output  1  at least one legal code accepted since reset.
- locked  output  1  FSM in LOCKED.
- code_err  output  1  one-cycle pulse: illegal pattern sampled.
- seq_err  output  1  one-cycle pulse: legal code but wrong step while LOCKED.
- err_cnt  output  8  saturating count of code_err + seq_err events.

Behaviour:
- Legal map, for k = 0..N:
  - Index k: the low k bits are 1, the rest are 0.
  - Index N+j (j = 1..N-1): bits [j-1:0] are 0 and bits [N-1:j] are 1.
  - N=4 map: 0000→0, 0001→1, 0011→2, 0111→3, 1111→4, 1110→5, 1100→6, 1000→7.
  - Every other pattern is illegal.
- Successor of index i is (i+1) mod 2N; 7→0 is a legal step for N=4.
- Reset (rst=0, asynchronous) drives: idx=0, onehot=0, out_vld=0, locked=0, code_err=0, seq_err=0, err_cnt=0, match_cnt=0, FSM=UNLOCKED.
- Latency: all outputs are registered and update on the clk edge where valid=1. Pulse outputs are high for exactly that one cycle.
- valid=0:
  - No state change.
  - code_err and seq_err are 0.
  - code is ignored, including illegal or X values.
- Illegal code (valid=1):
  - code_err=1.
  - idx, onehot and out_vld hold.
  - FSM goes to UNLOCKED and match_cnt=0.
  - The next legal code is treated as the first reference (no successor check).
- Legal code, no reference yet (first after reset or after an illegal code):
  - idx and onehot load; out_vld=1.
  - match_cnt=0.
- Legal code, repeat of the current idx:
  - Accepted as a hold, with no error.
  - match_cnt and FSM unchanged.
- Legal code, successor of idx, state UNLOCKED:
  - idx loads; match_cnt++.
  - If the new match_cnt == LOCK_CNT, go to LOCKED and set locked=1 on the same edge.
- Legal code, successor of idx, state LOCKED: idx loads; no other change.
- Legal code, neither repeat nor successor:
  - idx loads (used as the new reference); match_cnt=0.
  - If LOCKED: seq_err=1 and FSM goes to UNLOCKED.
  - If UNLOCKED: no error, just resync.
- err_cnt:
  - +1 on each code_err or seq_err; saturates at 255.
  - err_clr=1 sets it to 0. If an error occurs on the same edge as err_clr, the result is 1.
- FSM: two states.
  - UNLOCKED → LOCKED: only via the match_cnt condition above.
  - LOCKED → UNLOCKED: on code_err or seq_err.
- onehot[idx] = 1 whenever out_vld=1.
- Reset mid-operation: outputs are cleared immediately, without waiting for clk. The first clk edge after rst deasserts behaves as first-sample-after-reset.

Test Plan:
- Lock: N=4, LOCK_CNT=3; valid=1 with codes 0000, 0001, 0011, 0111 → locked=1 after the 4th edge; idx=3, onehot=00001000, err_cnt=0.
- Illegal code: while locked, code 0101 → code_err pulses 1 cycle, locked=0, idx holds 3, err_cnt=1. Then 0111, 1111, 1110, 1100 → locked=1 again, idx=6.
- Skip and wrap:
  - While locked at idx=2 (0011), code 1111 → seq_err=1, locked=0, idx=4, err_cnt++.
  - Separately, 1100 → 1000 → 0000 → 0001 while locked gives no errors, and idx passes 6, 7, 0, 1.
- Hold and valid gaps: repeat 0011 three times with valid=1, interleaved with valid=0 cycles carrying 1010 → no errors, idx stays 2, locked unchanged.
- Counter edges:
  - 260 illegal samples → err_cnt=255, holds there.
  - err_clr together with an illegal sample → err_cnt=1.
  - err_clr alone → err_cnt=0.
- Async reset: drop rst mid-cycle while locked → all outputs 0 before the next clk edge. Release rst, then code 1110 → out_vld=1, idx=5, locked=0, no error.
